// File: rtl/rm_lane_checker_pkg.sv
// Shared constants and alarm types for the runtime-monitor lane checker.
package rm_lane_checker_pkg;

  localparam int RM_NUM_LANES  = 5;
  localparam int RM_NUM_EVENTS = 10;
  localparam int RM_NUM_ITYPES = 2;
  localparam int RM_NUM_STEPS  = 4;
  localparam int RM_TIMEOUT_W  = 8;

  localparam int RM_LANE_W  = (RM_NUM_LANES > 1) ? $clog2(RM_NUM_LANES) : 1;
  localparam int RM_ITYPE_W = (RM_NUM_ITYPES > 1) ? $clog2(RM_NUM_ITYPES) : 1;
  localparam int RM_STEP_W  = (RM_NUM_STEPS > 1) ? $clog2(RM_NUM_STEPS) : 1;
  localparam int RM_NSTEP_W = $clog2(RM_NUM_STEPS + 1);

  typedef enum logic [1:0] {
    RM_NONE    = 2'd0,
    RM_ORDER   = 2'd1,
    RM_TIMEOUT = 2'd2,
    RM_ITYPE   = 2'd3
  } rm_alarm_cause_e;

  typedef struct packed {
    logic [RM_LANE_W-1:0]  lane;
    logic [RM_ITYPE_W-1:0] itype;
    logic [RM_STEP_W-1:0]  step;
    rm_alarm_cause_e       cause;
  } rm_alarm_t;

endpackage

// File: rtl/rm_lane_checker_fsm.sv
// Per-lane sequence tracker: follows one instruction's events through the programmed steps.
module rm_lane_fsm
  import rm_lane_checker_pkg::*;
#(
  parameter int NUM_EVENTS        = RM_NUM_EVENTS,
  parameter int NUM_MONITORED_INS = RM_NUM_ITYPES,
  parameter int NUM_STEPS         = RM_NUM_STEPS,
  parameter int TIMEOUT_W         = RM_TIMEOUT_W
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_ni,
  input  logic [NUM_MONITORED_INS-1:0][NUM_EVENTS-1:0]          lane_vector,
  input  logic                                                  lane_reset,
  input  logic                                                  cfg_en,
  input  logic [NUM_MONITORED_INS-1:0][NUM_STEPS-1:0][NUM_EVENTS-1:0] cfg_step_mask,
  input  logic [NUM_MONITORED_INS-1:0][RM_NSTEP_W-1:0]          cfg_num_steps,
  input  logic [TIMEOUT_W-1:0]                                  cfg_timeout,
  input  logic                                                  alarm_ack,
  output logic                                                  alarm_req,
  output logic [RM_ITYPE_W-1:0]                                 alarm_itype,
  output logic [RM_STEP_W-1:0]                                  alarm_step,
  output rm_alarm_cause_e                                       alarm_cause,
  output logic                                                  busy,
  output logic                                                  done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_ALARM = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [RM_ITYPE_W-1:0] itype_q, itype_d, cur_itype;
  logic [RM_STEP_W-1:0]  step_q, step_d, cur_step;
  logic [NUM_EVENTS-1:0] seen_q, seen_d, seen_n, ev, mask;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
  rm_alarm_cause_e       cause_q, cause_d;
  logic                  done_q, done_d;
  logic [RM_NSTEP_W-1:0] nsteps;
  logic                  any_ev, other_ev, order_err, tmo_hit, last_step, eval;

  function automatic logic [TIMEOUT_W-1:0] sat_inc(input logic [TIMEOUT_W-1:0] v);
    return (&v) ? v : v + TIMEOUT_W'(1);
  endfunction

  // An idle lane adopts the lowest itype showing activity; a tracking lane keeps its latched one.
  always_comb begin
    cur_itype = itype_q;
    if (state_q == ST_IDLE) begin
      cur_itype = '0;
      for (int i = NUM_MONITORED_INS - 1; i >= 0; i--)
        if (|lane_vector[i]) cur_itype = RM_ITYPE_W'(i);
    end
    other_ev = 1'b0;
    for (int i = 0; i < NUM_MONITORED_INS; i++)
      if (RM_ITYPE_W'(i) != cur_itype) other_ev = other_ev | (|lane_vector[i]);
  end

  assign cur_step  = (state_q == ST_IDLE) ? '0 : step_q;
  assign ev        = lane_vector[cur_itype];
  assign any_ev    = |lane_vector;
  assign mask      = cfg_step_mask[cur_itype][cur_step];
  assign nsteps    = cfg_num_steps[cur_itype];
  assign seen_n    = ((state_q == ST_IDLE) ? '0 : seen_q) | ev;
  assign order_err = |(ev & ~mask);
  assign tmo_hit   = (state_q == ST_TRACK) && (cfg_timeout != '0) && (cnt_q == cfg_timeout);
  assign last_step = (RM_NSTEP_W'(cur_step) + RM_NSTEP_W'(1)) == nsteps;

  always_comb begin
    state_d = state_q;
    itype_d = itype_q;
    step_d  = step_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    done_d  = 1'b0;
    eval    = 1'b0;
    case (state_q)
      ST_IDLE:  eval = !lane_reset && cfg_en && any_ev && (nsteps != '0);
      ST_TRACK: begin
        if (lane_reset || !cfg_en) begin
          state_d = ST_IDLE;
          step_d  = '0;
          seen_d  = '0;
          cnt_d   = '0;
        end else begin
          eval = 1'b1;
        end
      end
      ST_ALARM: begin
        if (alarm_ack) begin
          state_d = ST_IDLE;
          step_d  = '0;
          seen_d  = '0;
          cnt_d   = '0;
          cause_d = RM_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Fault precedence: foreign itype, then out-of-order event, then stall, then progress.
    if (eval) begin
      state_d = ST_TRACK;
      itype_d = cur_itype;
      step_d  = cur_step;
      seen_d  = seen_n;
      cnt_d   = (|ev) ? '0 : sat_inc(cnt_q);
      if (other_ev) begin
        state_d = ST_ALARM;
        cause_d = RM_ITYPE;
      end else if (order_err) begin
        state_d = ST_ALARM;
        cause_d = RM_ORDER;
      end else if (tmo_hit) begin
        state_d = ST_ALARM;
        cause_d = RM_TIMEOUT;
      end else if (seen_n == mask) begin
        seen_d = '0;
        cnt_d  = '0;
        if (last_step) begin
          state_d = ST_IDLE;
          step_d  = '0;
          done_d  = 1'b1;
        end else begin
          step_d = cur_step + RM_STEP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      itype_q <= '0;
      step_q  <= '0;
      seen_q  <= '0;
      cnt_q   <= '0;
      cause_q <= RM_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      itype_q <= itype_d;
      step_q  <= step_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      done_q  <= done_d;
    end
  end

  assign alarm_req   = (state_q == ST_ALARM);
  assign alarm_itype = itype_q;
  assign alarm_step  = step_q;
  assign alarm_cause = cause_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;

endmodule

// File: rtl/rm_lane_checker.sv
// Checks each router lane against its programmed step sequence and arbitrates lane alarms onto one port.
module rm_lane_checker
  import rm_lane_checker_pkg::*;
#(
  parameter int NUM_LANES         = RM_NUM_LANES,
  parameter int NUM_EVENTS        = RM_NUM_EVENTS,
  parameter int NUM_MONITORED_INS = RM_NUM_ITYPES,
  parameter int NUM_STEPS         = RM_NUM_STEPS,
  parameter int TIMEOUT_W         = RM_TIMEOUT_W
) (
  input  logic                                                          clk_i,
  input  logic                                                          rst_ni,
  input  logic [NUM_LANES-1:0][NUM_MONITORED_INS-1:0][NUM_EVENTS-1:0]   lane_vector_i,
  input  logic [NUM_LANES-1:0]                                          lane_reset_i,
  input  logic                                                          cfg_en_i,
  input  logic [NUM_MONITORED_INS-1:0][NUM_STEPS-1:0][NUM_EVENTS-1:0]   cfg_step_mask_i,
  input  logic [NUM_MONITORED_INS-1:0][RM_NSTEP_W-1:0]                  cfg_num_steps_i,
  input  logic [TIMEOUT_W-1:0]                                          cfg_timeout_i,
  output logic                                                          alarm_valid_o,
  input  logic                                                          alarm_ready_i,
  output rm_alarm_t                                                     alarm_o,
  output logic [NUM_LANES-1:0]                                          lane_busy_o,
  output logic [NUM_LANES-1:0]                                          lane_done_o
);

  logic [NUM_LANES-1:0]  req, ack, eligible;
  logic [RM_ITYPE_W-1:0] lane_itype [NUM_LANES];
  logic [RM_STEP_W-1:0]  lane_step  [NUM_LANES];
  rm_alarm_cause_e       lane_cause [NUM_LANES];
  logic [RM_LANE_W-1:0]  rr_ptr_q, win_idx, cand;
  logic                  win_found, load;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign ack[l] = alarm_valid_o && alarm_ready_i && (alarm_o.lane == RM_LANE_W'(l));

    rm_lane_fsm #(
      .NUM_EVENTS       (NUM_EVENTS),
      .NUM_MONITORED_INS(NUM_MONITORED_INS),
      .NUM_STEPS        (NUM_STEPS),
      .TIMEOUT_W        (TIMEOUT_W)
    ) u_fsm (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .lane_vector  (lane_vector_i[l]),
      .lane_reset   (lane_reset_i[l]),
      .cfg_en       (cfg_en_i),
      .cfg_step_mask(cfg_step_mask_i),
      .cfg_num_steps(cfg_num_steps_i),
      .cfg_timeout  (cfg_timeout_i),
      .alarm_ack    (ack[l]),
      .alarm_req    (req[l]),
      .alarm_itype  (lane_itype[l]),
      .alarm_step   (lane_step[l]),
      .alarm_cause  (lane_cause[l]),
      .busy         (lane_busy_o[l]),
      .done         (lane_done_o[l])
    );
  end

  // The lane already sitting in the output register must not be granted a second time.
  assign eligible = req & ~(alarm_valid_o ? (NUM_LANES'(1) << alarm_o.lane) : '0);
  assign load     = !alarm_valid_o || alarm_ready_i;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      cand = RM_LANE_W'((int'(rr_ptr_q) + k) % NUM_LANES);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alarm_valid_o <= 1'b0;
      alarm_o       <= '0;
      rr_ptr_q      <= RM_LANE_W'(NUM_LANES - 1);
    end else if (load) begin
      alarm_valid_o <= win_found;
      if (win_found) begin
        alarm_o  <= '{lane: win_idx, itype: lane_itype[win_idx],
                      step: lane_step[win_idx], cause: lane_cause[win_idx]};
        rr_ptr_q <= win_idx;
      end else begin
        alarm_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rm_lane_checker.sv
// Bench for rm_lane_checker: directed table, hand-written corner sequences, then random traffic vs a model.
module tb_rm_lane_checker;
  import rm_lane_checker_pkg::*;

  localparam int NL = RM_NUM_LANES;
  localparam int NI = RM_NUM_ITYPES;
  localparam int NE = RM_NUM_EVENTS;
  localparam int NS = RM_NUM_STEPS;

  logic clk = 1'b0;
  logic rst_n;
  logic [NL-1:0][NI-1:0][NE-1:0] vec;
  logic [NL-1:0] lrst;
  logic cfg_en;
  logic [NI-1:0][NS-1:0][NE-1:0] mask_cfg;
  logic [NI-1:0][RM_NSTEP_W-1:0] nsteps_cfg;
  logic [RM_TIMEOUT_W-1:0] tmo_cfg;
  logic valid, ready;
  rm_alarm_t alarm;
  logic [NL-1:0] busy, done;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rm_lane_checker dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .lane_vector_i  (vec),
    .lane_reset_i   (lrst),
    .cfg_en_i       (cfg_en),
    .cfg_step_mask_i(mask_cfg),
    .cfg_num_steps_i(nsteps_cfg),
    .cfg_timeout_i  (tmo_cfg),
    .alarm_valid_o  (valid),
    .alarm_ready_i  (ready),
    .alarm_o        (alarm),
    .lane_busy_o    (busy),
    .lane_done_o    (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rm_alarm_t mk_alarm(input int l, input int it, input int st, input int c);
    rm_alarm_t a;
    a.lane  = RM_LANE_W'(l);
    a.itype = RM_ITYPE_W'(it);
    a.step  = RM_STEP_W'(st);
    a.cause = rm_alarm_cause_e'(c);
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vec   = '0;
    lrst  = '0;
    ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit   trk;
    bit   alm;
    int   it;
    int   st;
    logic [NE-1:0] seen;
    int   idle;
    int   cause;
  } lm_t;

  lm_t lm [NL];
  bit m_vld;
  rm_alarm_t m_al;
  int m_last;
  logic [NL-1:0] m_done;

  function automatic void clear_lane(input int l);
    lm[l].trk = 0; lm[l].alm = 0; lm[l].st = 0; lm[l].seen = '0; lm[l].idle = 0; lm[l].cause = 0;
  endfunction

  function automatic void model_reset();
    for (int l = 0; l < NL; l++) begin
      clear_lane(l);
      lm[l].it = 0;
    end
    m_vld = 0; m_al = '0; m_last = NL - 1; m_done = '0;
  endfunction

  function automatic void raise(input int l, input int c);
    lm[l].alm = 1; lm[l].trk = 0; lm[l].cause = c;
  endfunction

  function automatic void lane_model(input int l, input bit acked);
    int it;
    logic [NE-1:0] ev, m;
    bit other, was_trk;
    m_done[l] = 1'b0;
    if (lm[l].alm) begin
      if (acked) clear_lane(l);
      return;
    end
    if (lrst[l] || (lm[l].trk && !cfg_en)) begin
      clear_lane(l);
      return;
    end
    was_trk = lm[l].trk;
    if (!was_trk) begin
      if (!cfg_en || vec[l] == '0) return;
      it = 0;
      for (int i = NI - 1; i >= 0; i--) if (vec[l][i] != '0) it = i;
      if (nsteps_cfg[it] == 0) return;
      lm[l].it = it; lm[l].st = 0; lm[l].seen = '0; lm[l].idle = 0;
    end
    it = lm[l].it;
    ev = vec[l][it];
    other = 0;
    for (int i = 0; i < NI; i++) if (i != it && vec[l][i] != '0) other = 1;
    m = mask_cfg[it][lm[l].st];
    if (other) raise(l, 3);
    else if ((ev & ~m) != '0) raise(l, 1);
    else if (was_trk && tmo_cfg != 0 && lm[l].idle == int'(tmo_cfg)) raise(l, 2);
    else begin
      lm[l].seen = lm[l].seen | ev;
      if (lm[l].seen == m) begin
        lm[l].st++;
        lm[l].seen = '0;
        lm[l].idle = 0;
        if (lm[l].st == int'(nsteps_cfg[it])) begin
          m_done[l] = 1'b1; lm[l].trk = 0; lm[l].st = 0;
        end else lm[l].trk = 1;
      end else begin
        lm[l].trk = 1;
        lm[l].idle = (ev != '0) ? 0 : ((lm[l].idle < 255) ? lm[l].idle + 1 : 255);
      end
    end
  endfunction

  function automatic void model_step();
    int acc, pick, cl;
    acc = (m_vld && ready) ? int'(m_al.lane) : -1;
    if (!m_vld || ready) begin
      pick = -1;
      for (int k = 1; k <= NL; k++) begin
        cl = (m_last + k) % NL;
        if (pick < 0 && lm[cl].alm && cl != acc) pick = cl;
      end
      if (pick >= 0) begin
        m_vld = 1;
        m_al = mk_alarm(pick, lm[pick].it, lm[pick].st, lm[pick].cause);
        m_last = pick;
      end else begin
        m_vld = 0;
        m_al = '0;
      end
    end
    for (int l = 0; l < NL; l++) lane_model(l, acc == l);
  endfunction

  // ---------------- directed pieces ----------------
  typedef struct {
    logic [NE-1:0] ev;
    logic rst;
    logic rdy;
    logic busy;
    logic done;
    logic vld;
    rm_alarm_t al;
  } row_t;

  task automatic triple(input int a, input int b, input int c, input string tag);
    int ord[3];
    ord[0] = a; ord[1] = b; ord[2] = c;
    ready = 1'b1;
    vec[0][0] = 10'h010; vec[3][0] = 10'h010; vec[4][0] = 10'h010;
    tick();
    vec = '0;
    check({tag, "_all_alarm"}, busy, 5'b11001);
    for (int i = 0; i < 3; i++) begin
      tick();
      check({tag, "_order"}, {valid, alarm}, {1'b1, mk_alarm(ord[i], 0, 0, 1)});
    end
    tick();
    check({tag, "_drain"}, {valid, busy}, {1'b0, 5'b00000});
  endtask

  row_t tbl[10];
  logic [NE-1:0] pool0[7];
  logic [NE-1:0] pool1[9];

  initial begin
    tbl[0] = '{10'h001, 0, 1, 1, 0, 0, '0};
    tbl[1] = '{10'h002, 0, 1, 1, 0, 0, '0};
    tbl[2] = '{10'h00C, 0, 1, 0, 1, 0, '0};
    tbl[3] = '{10'h000, 0, 1, 0, 0, 0, '0};
    tbl[4] = '{10'h003, 0, 1, 1, 0, 0, '0};
    tbl[5] = '{10'h00C, 1, 1, 0, 0, 0, '0};
    tbl[6] = '{10'h000, 0, 1, 0, 0, 0, '0};
    tbl[7] = '{10'h004, 0, 0, 1, 0, 0, '0};
    tbl[8] = '{10'h000, 1, 0, 1, 0, 1, mk_alarm(2, 0, 0, 1)};
    tbl[9] = '{10'h000, 1, 1, 0, 0, 0, '0};
    pool0 = '{10'h001, 10'h002, 10'h003, 10'h004, 10'h008, 10'h00C, 10'h010};
    pool1 = '{10'h010, 10'h020, 10'h030, 10'h040, 10'h080, 10'h0C0, 10'h100, 10'h200, 10'h300};

    mask_cfg = '0;
    mask_cfg[0][0] = 10'h003; mask_cfg[0][1] = 10'h00C;
    mask_cfg[1][0] = 10'h030; mask_cfg[1][1] = 10'h0C0; mask_cfg[1][2] = 10'h300;
    nsteps_cfg[0] = RM_NSTEP_W'(2);
    nsteps_cfg[1] = RM_NSTEP_W'(3);
    tmo_cfg = '0;
    cfg_en  = 1'b1;
    vec = '0; lrst = '0; ready = 1'b0;

    rst_n = 1'b0;
    #3;
    check("reset_valid", valid, 1'b0);
    check("reset_alarm", alarm, '0);
    check("reset_busy", busy, '0);
    check("reset_done", done, '0);
    do_reset();

    // lane 2 sequence, reset racing completion, reset ignored while alarmed
    for (int i = 0; i < 10; i++) begin
      vec[2][0] = tbl[i].ev;
      lrst[2]   = tbl[i].rst;
      ready     = tbl[i].rdy;
      tick();
      check("tbl_busy", busy, {2'b00, tbl[i].busy, 2'b00});
      check("tbl_done", done, {2'b00, tbl[i].done, 2'b00});
      check("tbl_valid", valid, tbl[i].vld);
      check("tbl_alarm", alarm, tbl[i].al);
    end
    vec = '0; lrst = '0;

    // ORDER alarm on lane 1, held under backpressure
    ready = 1'b0;
    vec[1][0] = 10'h001;
    tick();
    check("ord_track", busy, 5'b00010);
    vec[1][0] = 10'h010;
    tick();
    vec = '0;
    check("ord_not_yet", valid, 1'b0);
    tick();
    check("ord_alarm", {valid, alarm}, {1'b1, mk_alarm(1, 0, 0, 1)});
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ord_hold", {valid, alarm}, {1'b1, mk_alarm(1, 0, 0, 1)});
    end
    ready = 1'b1;
    tick();
    check("ord_accept", {valid, busy}, {1'b0, 5'b00000});

    // TIMEOUT on lane 0 at step 1
    tmo_cfg = 8'd4;
    vec[0][0] = 10'h003;
    tick();
    vec = '0;
    for (int q = 1; q <= 5; q++) begin
      tick();
      check("tmo_quiet", {valid, busy[0]}, {1'b0, 1'b1});
    end
    tick();
    check("tmo_alarm", {valid, alarm}, {1'b1, mk_alarm(0, 0, 1, 2)});
    tick();
    check("tmo_accept", {valid, busy}, {1'b0, 5'b00000});
    tmo_cfg = '0;

    // round-robin from a fresh pointer, then after lane 3 was last granted
    do_reset();
    triple(0, 3, 4, "rr_a");
    vec[3][0] = 10'h010;
    tick();
    vec = '0;
    tick();
    check("rr_single", {valid, alarm}, {1'b1, mk_alarm(3, 0, 0, 1)});
    tick();
    check("rr_single_drain", valid, 1'b0);
    triple(4, 0, 3, "rr_b");

    // asynchronous reset with an alarm pending and a lane tracking
    ready = 1'b0;
    vec[0][0] = 10'h010;
    vec[1][0] = 10'h001;
    tick();
    vec = '0;
    tick();
    check("arst_pre", {valid, busy}, {1'b1, 5'b00011});
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", valid, 1'b0);
    check("arst_busy", busy, 5'b00000);
    check("arst_alarm", alarm, '0);
    tick();
    rst_n = 1'b1;

    // randomized traffic against the model
    do_reset();
    model_reset();
    for (int seg = 0; seg < 2; seg++) begin
      tmo_cfg = (seg == 0) ? 8'd5 : 8'd0;
      for (int n = 0; n < 1500; n++) begin
        logic [NL-1:0] exp_busy;
        int r;
        ready  = ($urandom_range(0, 9) < 7);
        cfg_en = ($urandom_range(0, 49) != 0);
        vec = '0;
        for (int l = 0; l < NL; l++) begin
          lrst[l] = ($urandom_range(0, 39) == 0);
          r = $urandom_range(0, 99);
          if (r >= 55 && r < 90) vec[l][0] = pool0[$urandom_range(0, 6)];
          else if (r >= 90 && r < 97) vec[l][1] = pool1[$urandom_range(0, 8)];
          else if (r >= 97) begin
            vec[l][0] = pool0[$urandom_range(0, 6)];
            vec[l][1] = pool1[$urandom_range(0, 8)];
          end
        end
        model_step();
        tick();
        for (int l = 0; l < NL; l++) exp_busy[l] = lm[l].trk || lm[l].alm;
        check("rand_alarm", {valid, alarm}, {m_vld, m_al});
        check("rand_lanes", {busy, done}, {exp_busy, m_done});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
